// File: rtl/demux_router.sv
// demux_router_fifo: circular-buffer byte queue for one channel; the head appears one cycle after a push.
// Latency 1 cycle. Pushes are ignored while full, pops are ignored while empty.
// rd_dat reads as zero while the queue is empty.
module demux_router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             full,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign full   = (count == CW'(DEPTH));
  assign rd_vld = (count != '0);
  assign push   = wr_vld & ~full;
  assign pop    = rd_vld & rd_rdy;
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// demux_router: steers each input byte to one of four channel FIFOs; bytes for disabled channels are dropped and counted.
// Latency 1 cycle from accept to out_valid. in_ready falls only when the selected channel is enabled and full.
// A full enabled destination therefore stalls the whole input.
module demux_router #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_sel,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [3:0]         ch_en,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         sel_onehot,
  output logic [CNT_W-1:0]   drop_cnt
);
  logic [3:0] full;
  logic       sel_en;
  logic       accept;

  assign sel_en   = ch_en[in_sel];
  assign in_ready = ~reset & (~sel_en | ~full[in_sel]);
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    demux_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr_vld (accept & sel_en & (in_sel == 2'(k))),
      .wr_dat (in_data),
      .full   (full[k]),
      .rd_vld (out_valid[k]),
      .rd_rdy (out_ready[k]),
      .rd_dat (out_data[k*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_onehot <= '0;
      drop_cnt   <= '0;
    end else if (accept) begin
      sel_onehot <= 4'b0001 << in_sel;
      // Saturate rather than wrap, so a stuck-disabled channel stays visible.
      if (!sel_en && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_demux_router.sv
// Directed and random bench for demux_router, checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_demux_router;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_sel;
  logic [WIDTH-1:0]  in_data;
  logic [3:0]        ch_en;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]        sel_onehot;
  logic [CNT_W-1:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus drop count and last selection.
  logic [7:0] q [4][$];
  int         m_drop = 0;
  logic [3:0] m_oh = 4'b0000;
  logic       last_acc = 1'b0;

  always #5 clk = ~clk;

  demux_router #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .ch_en      (ch_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sel_onehot (sel_onehot),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic [3:0]  m_valid;
    logic [31:0] m_data;
    logic        m_rdy;
    @(negedge clk);
    m_rdy = !reset && (!ch_en[in_sel] || q[in_sel].size() < DEPTH);
    m_data = '0;
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = (q[k].size() > 0);
      if (m_valid[k]) m_data[k*8 +: 8] = q[k][0];
    end
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", out_data, m_data);
    chk("sel_onehot", 32'(sel_onehot), 32'(m_oh));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    @(posedge clk);
    last_acc = in_valid && m_rdy;
    if (reset) begin
      for (int k = 0; k < 4; k++) q[k].delete();
      m_drop = 0;
      m_oh   = 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++)
        if (m_valid[k] && out_ready[k]) void'(q[k].pop_front());
      if (in_valid && m_rdy) begin
        if (ch_en[in_sel]) q[in_sel].push_back(in_data);
        else if (m_drop < (1 << CNT_W) - 1) m_drop++;
        m_oh = 4'b0001 << in_sel;
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00;
    ch_en = 4'hF; out_ready = 4'h0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);

    // Single push to channel 2.
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA1;
    tick();
    in_valid = 1'b0;
    chk("a1_valid", 32'(out_valid), 32'h4);
    chk("a1_data", 32'(out_data[23:16]), 32'hA1);
    chk("a1_onehot", 32'(sel_onehot), 32'h4);
    out_ready = 4'b0100; tick(); out_ready = 4'h0;

    // Fill channel 0 to depth; third byte stalls until the first pop.
    in_valid = 1'b1; in_sel = 2'd0;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33;
    chk("full_stall", 32'(in_ready), 32'h0);
    tick();
    out_ready = 4'b0001;
    chk("head_11", 32'(out_data[7:0]), 32'h11);
    tick();
    chk("head_22", 32'(out_data[7:0]), 32'h22);
    tick();
    in_valid = 1'b0;
    chk("head_33", 32'(out_data[7:0]), 32'h33);
    tick();
    out_ready = 4'h0;
    chk("drained", 32'(out_valid), 32'h0);

    // Simultaneous push and pop on a one-entry channel.
    in_valid = 1'b1; in_data = 8'h55; tick();
    in_data = 8'h44; out_ready = 4'b0001; tick();
    in_valid = 1'b0; out_ready = 4'h0;
    chk("pp_valid", 32'(out_valid[0]), 32'h1);
    chk("pp_head", 32'(out_data[7:0]), 32'h44);
    out_ready = 4'b0001; tick(); out_ready = 4'h0;

    // Discards to a disabled channel.
    ch_en = 4'b1110; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h77;
    repeat (3) tick();
    chk("drop3", 32'(drop_cnt), 32'd3);
    chk("drop_onehot", 32'(sel_onehot), 32'h1);
    chk("drop_novalid", 32'(out_valid[0]), 32'h0);
    repeat (297) tick();
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    // Reset with queued data and a pending input.
    ch_en = 4'hF; in_sel = 2'd1; in_data = 8'hB1; tick(); in_data = 8'hB2; tick();
    in_sel = 2'd3; in_data = 8'hD1; tick(); in_data = 8'hD2; tick();
    reset = 1'b1; in_sel = 2'd1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_data", out_data, 32'h0);
    chk("mrst_drop", 32'(drop_cnt), 32'h0);
    chk("mrst_onehot", 32'(sel_onehot), 32'h0);

    // Random traffic; the producer holds its byte while stalled.
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom);
      out_ready = 4'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick();
      if (reset) last_acc = 1'b1;
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Inverse of the select/encode path: one 8-bit input stream carries a 2-bit destination select, and the block distributes each byte to one of four output channels.
- Each channel has a small registered FIFO with its own valid/ready handshake, plus an enable. This gives gated-register behaviour at channel level.
- Bytes addressed to a disabled channel are accepted and then discarded, and each discard is counted.
- Sits between a single byte producer and four independent byte consumers (ADD/PR datapaths, etc.).

Parameters:
- WIDTH, 8, data width per byte.
- DEPTH, 2, entries per channel FIFO; power of two, >= 2.
- CNT_W, 8, width of drop counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  producer has a byte.
- in_ready  output  1  block accepts the byte this cycle.
- in_sel  input  2  destination channel 0..3.
- in_data  input  WIDTH  byte.
- ch_en  input  4  per-channel enable; 0 = discard bytes addressed there.
- out_valid  output  4  channel k FIFO non-empty.
- out_ready  input  4  consumer k takes head.
- out_data  output  4*WIDTH  channel k head at bits [k*WIDTH +: WIDTH].
- sel_onehot  output  4  registered one-hot decode of last accepted in_sel.
- drop_cnt  output  CNT_W  saturating count of discarded bytes.

Behaviour:
- Reset (synchronous, edge with reset=1):
  - All FIFOs are emptied.
  - out_valid=0, out_data=0, sel_onehot=0, drop_cnt=0.
  - in_ready is driven 0 while reset=1, so no transfer occurs on a reset edge.
- in_ready (combinational) = ~reset & (~ch_en[in_sel] | ~full[in_sel]).
  - Depends only on in_sel, ch_en and registered fill state.
  - Never depends on out_ready, so there is no same-cycle pass-through when a FIFO is full.
- Accept = in_valid & in_ready, evaluated at the rising edge.
  - If ch_en[in_sel]=1: push in_data into FIFO[in_sel].
  - If ch_en[in_sel]=0: discard the byte; drop_cnt increments, saturating at 2^CNT_W-1 with no wrap.
  - On every accept, including discards, sel_onehot <= 1<<in_sel.
  - sel_onehot holds otherwise.
- Pop on channel k = out_valid[k] & out_ready[k] at the edge; the FIFO head advances.
- Latency: a byte pushed at edge N is visible on out_data[k] with out_valid[k]=1 after edge N (1 cycle).
- out_data[k] = 0 whenever out_valid[k]=0; output is driven from registered storage.
- FIFO per channel:
  - Circular buffer with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - Count 0..DEPTH.
  - full = (count==DEPTH), empty = (count==0).
  - Push and pop on the same edge, channel non-empty: count unchanged, both pointers advance.
  - Push on full: impossible (in_ready=0).
  - Pop on empty: ignored (out_valid=0).
- Ordering: strict FIFO order within a channel; no ordering between channels.
- Head-of-line blocking: a full, enabled destination stalls the whole input, which is accepted behaviour. Other channels continue to drain.
- ch_en changes:
  - Affect only new accepts.
  - Contents already queued in a FIFO are retained and drain normally even if ch_en[k] later drops to 0.
- in_sel and in_data may change freely while in_valid=0. The producer holds them stable while in_valid=1 & in_ready=0.
- Synchronous reset mid-transfer: queued data is lost, counters clear, and outputs read 0 the cycle after.

Test Plan:
- Reset, ch_en=4'hF, push 0xA1 sel=2 -> after 1 edge out_valid=4'b0100, out_data[2]=0xA1, sel_onehot=4'b0100, drop_cnt=0.
- Push 0x11,0x22,0x33 to ch0 with out_ready[0]=0, DEPTH=2 -> in_ready=0 on third byte; then raise out_ready[0] -> pops 0x11,0x22,0x33 in order, third accepted only after first pop.
- ch0 holds 1 entry; push 0x44 and pop on the same edge -> count stays 1, head becomes 0x44.
- ch_en=4'b1110, send 3 bytes sel=0 -> all accepted (in_ready=1), out_valid[0] stays 0, drop_cnt=3, sel_onehot=4'b0001.
- CNT_W=8, 300 discards -> drop_cnt saturates at 255.
- Fill ch1 and ch3 (2 each), assert reset for 1 cycle with in_valid=1 -> in_ready=0 during reset; afterwards out_valid=0, out_data=0, drop_cnt=0, sel_onehot=0.
